// File: rtl/hwce_tcdm_pkg.sv
// Shared TCDM (LINT) definitions for the HWCE port multiplexer.
// Request type encoding, a default-width request bundle and the round-robin step helper.
package hwce_tcdm_pkg;

  localparam logic TCDM_TYPE_READ  = 1'b1;
  localparam logic TCDM_TYPE_WRITE = 1'b0;

  localparam int unsigned TCDM_ADDR_WIDTH = 32;
  localparam int unsigned TCDM_DATA_WIDTH = 32;
  localparam int unsigned TCDM_BE_WIDTH   = TCDM_DATA_WIDTH / 8;

  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       type_;
    logic [TCDM_BE_WIDTH-1:0]   be;
    logic [TCDM_DATA_WIDTH-1:0] data;
  } tcdm_req_t;

  // Port index following cur, wrapping at n.
  function automatic int unsigned rr_next_idx(input int unsigned cur, input int unsigned n);
    return (cur == n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/hwce_tcdm_id_fifo.sv
// In-order FIFO of initiator port IDs for granted-but-unanswered TCDM requests.
// Flop-based; push is ignored when full and pop is ignored when empty.
module hwce_tcdm_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hwce_tcdm_port_mux.sv
// Round-robin merge of N_IN HWCE TCDM initiator ports onto one cluster TCDM port.
// Responses are steered back to the issuing port through an in-order ID FIFO.
module hwce_tcdm_port_mux
  import hwce_tcdm_pkg::*;
#(
  parameter int unsigned N_IN            = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IN-1:0]              in_req_i,
  output logic [N_IN-1:0]              in_gnt_o,
  input  logic [N_IN*ADDR_WIDTH-1:0]   in_add_i,
  input  logic [N_IN-1:0]              in_type_i,
  input  logic [N_IN*BE_WIDTH-1:0]     in_be_i,
  input  logic [N_IN*DATA_WIDTH-1:0]   in_data_i,
  output logic [N_IN*DATA_WIDTH-1:0]   in_r_data_o,
  output logic [N_IN-1:0]              in_r_valid_o,
  output logic                         out_req_o,
  input  logic                         out_gnt_i,
  output logic [ADDR_WIDTH-1:0]        out_add_o,
  output logic                         out_type_o,
  output logic [BE_WIDTH-1:0]          out_be_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  input  logic [DATA_WIDTH-1:0]        out_r_data_i,
  input  logic                         out_r_valid_i,
  output logic                         err_o
);

  localparam int unsigned IdxW = $clog2(N_IN);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING) + 1;

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] head_id;
  logic [CntW-1:0] id_count;
  logic            id_full, id_empty;
  logic            handshake, pop;
  logic            err_q, err_d;
  int unsigned     cand;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    sel  = '0;
    cand = 0;
    for (int unsigned i = N_IN; i > 0; i--) begin
      cand = int'(rr_ptr_q) + i - 1;
      if (cand >= N_IN) cand = cand - N_IN;
      if (in_req_i[IdxW'(cand)]) sel = IdxW'(cand);
    end
  end

  // Gated by rst so nothing is offered to the cluster while in reset.
  assign out_req_o = (|in_req_i) & ~id_full & ~rst;
  assign handshake = out_req_o & out_gnt_i;

  always_comb begin
    out_add_o  = '0;
    out_type_o = 1'b0;
    out_be_o   = '0;
    out_data_o = '0;
    in_gnt_o   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (out_req_o && sel == IdxW'(k)) begin
        out_add_o  = in_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        out_type_o = in_type_i[k];
        out_be_o   = in_be_i[k*BE_WIDTH +: BE_WIDTH];
        out_data_o = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        in_gnt_o[k] = out_gnt_i;
      end
    end
  end

  assign rr_ptr_d = handshake ? IdxW'(rr_next_idx(int'(sel), N_IN)) : rr_ptr_q;

  assign pop         = out_r_valid_i & ~id_empty;
  assign in_r_data_o = {N_IN{out_r_data_i}};
  assign err_d       = err_q | (out_r_valid_i & id_empty);
  assign err_o       = err_q;

  always_comb begin
    in_r_valid_o = '0;
    in_r_valid_o[head_id] = pop;
  end

  always_comb begin
    assert (rst || id_count <= CntW'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  hwce_tcdm_id_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (IdxW)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (id_full),
    .empty_o (id_empty),
    .count_o (id_count)
  );

endmodule

// File: tb/tb_hwce_tcdm_port_mux.sv
// Directed bench for hwce_tcdm_port_mux: round-robin order, backpressure, routing, error flag.
module tb_hwce_tcdm_port_mux;

  localparam int unsigned NIn = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NIn-1:0]    in_req_i;
  logic [NIn-1:0]    in_gnt_o;
  logic [NIn*AW-1:0] in_add_i;
  logic [NIn-1:0]    in_type_i;
  logic [NIn*BW-1:0] in_be_i;
  logic [NIn*DW-1:0] in_data_i;
  logic [NIn*DW-1:0] in_r_data_o;
  logic [NIn-1:0]    in_r_valid_o;
  logic              out_req_o;
  logic              out_gnt_i;
  logic [AW-1:0]     out_add_o;
  logic              out_type_o;
  logic [BW-1:0]     out_be_o;
  logic [DW-1:0]     out_data_o;
  logic [DW-1:0]     out_r_data_i;
  logic              out_r_valid_i;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] addr_tab [NIn];
  logic [2:0]    exp_v;

  always #5 clk = ~clk;

  hwce_tcdm_port_mux dut (
    .clk           (clk),
    .rst           (rst),
    .in_req_i      (in_req_i),
    .in_gnt_o      (in_gnt_o),
    .in_add_i      (in_add_i),
    .in_type_i     (in_type_i),
    .in_be_i       (in_be_i),
    .in_data_i     (in_data_i),
    .in_r_data_o   (in_r_data_o),
    .in_r_valid_o  (in_r_valid_o),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .out_add_o     (out_add_o),
    .out_type_o    (out_type_o),
    .out_be_o      (out_be_o),
    .out_data_o    (out_data_o),
    .out_r_data_i  (out_r_data_i),
    .out_r_valid_i (out_r_valid_i),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    addr_tab[0] = 32'h1000_0100;
    addr_tab[1] = 32'h2000_0200;
    addr_tab[2] = 32'h3000_0300;
    rst           = 1'b1;
    in_req_i      = '0;
    in_add_i      = {addr_tab[2], addr_tab[1], addr_tab[0]};
    in_type_i     = 3'b111;
    in_be_i       = {4'hF, 4'hF, 4'hF};
    in_data_i     = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    out_gnt_i     = 1'b0;
    out_r_data_i  = '0;
    out_r_valid_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 128'(out_req_o), 128'(1'b0));
    check("rst_gnt", 128'(in_gnt_o), 128'(3'b000));
    check("rst_err", 128'(err_o), 128'(1'b0));
    check("rst_add", 128'(out_add_o), 128'(32'h0));
    rst = 1'b0;

    // 1: all ports request, latency-1 responses
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_req_i      = 3'b111;
      out_gnt_i     = 1'b1;
      out_r_valid_i = (i != 0);
      out_r_data_i  = 32'hA000_0000 + 32'(i);
      #1;
      exp_v = 3'b001 << (i % 3);
      check("t1_gnt", 128'(in_gnt_o), 128'(exp_v));
      check("t1_add", 128'(out_add_o), 128'(addr_tab[i % 3]));
      exp_v = (i == 0) ? 3'b000 : (3'b001 << ((i - 1) % 3));
      check("t1_rvalid", 128'(in_r_valid_o), 128'(exp_v));
    end
    check("t1_rdata", 128'(in_r_data_o), 128'({3{32'hA000_0005}}));
    @(negedge clk);
    in_req_i      = '0;
    out_r_valid_i = 1'b1;
    #1;
    check("t1_drain", 128'(in_r_valid_o), 128'(3'b100));
    check("t1_noreq", 128'(out_req_o), 128'(1'b0));

    // 2: single requester, no bubbles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_req_i      = 3'b010;
      out_r_valid_i = (i != 0);
      #1;
      check("t2_gnt", 128'(in_gnt_o), 128'(3'b010));
      check("t2_add", 128'(out_add_o), 128'(addr_tab[1]));
      exp_v = (i == 0) ? 3'b000 : 3'b010;
      check("t2_rvalid", 128'(in_r_valid_o), 128'(exp_v));
      if (i > 0) check("t2_rrptr", 128'(dut.rr_ptr_q), 128'(2));
    end
    @(negedge clk);
    in_req_i      = '0;
    out_r_valid_i = 1'b1;
    #1;
    check("t2_drain", 128'(in_r_valid_o), 128'(3'b010));
    check("t2_rrptr_end", 128'(dut.rr_ptr_q), 128'(2));

    // 3: responses withheld until the FIFO fills
    @(negedge clk);
    in_req_i      = 3'b111;
    out_r_valid_i = 1'b0;
    #1;
    check("t3_gnt0", 128'(in_gnt_o), 128'(3'b100));
    @(negedge clk); #1;
    check("t3_gnt1", 128'(in_gnt_o), 128'(3'b001));
    @(negedge clk); #1;
    check("t3_gnt2", 128'(in_gnt_o), 128'(3'b010));
    @(negedge clk); #1;
    check("t3_gnt3", 128'(in_gnt_o), 128'(3'b100));
    @(negedge clk);
    out_r_valid_i = 1'b1;
    #1;
    check("t3_full_req", 128'(out_req_o), 128'(1'b0));
    check("t3_full_gnt", 128'(in_gnt_o), 128'(3'b000));
    check("t3_full_rv", 128'(in_r_valid_o), 128'(3'b100));
    @(negedge clk);
    out_r_valid_i = 1'b0;
    #1;
    check("t3_refill_req", 128'(out_req_o), 128'(1'b1));
    check("t3_refill_gnt", 128'(in_gnt_o), 128'(3'b001));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_req_i      = '0;
      out_r_valid_i = 1'b1;
      #1;
      exp_v = (i == 3) ? 3'b001 : (3'b001 << i);
      check("t3_drain", 128'(in_r_valid_o), 128'(exp_v));
    end

    // 4: port 2 write, latency 3
    @(negedge clk);
    out_r_valid_i = 1'b0;
    in_req_i      = 3'b100;
    in_type_i     = 3'b011;
    in_add_i[2*AW +: AW]  = 32'h1000_0040;
    in_be_i[2*BW +: BW]   = 4'b0011;
    in_data_i[2*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    check("t4_gnt", 128'(in_gnt_o), 128'(3'b100));
    check("t4_add", 128'(out_add_o), 128'(32'h1000_0040));
    check("t4_type", 128'(out_type_o), 128'(1'b0));
    check("t4_be", 128'(out_be_o), 128'(4'b0011));
    check("t4_data", 128'(out_data_o), 128'(32'hDEAD_BEEF));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_req_i = '0;
      #1;
      check("t4_wait_rv", 128'(in_r_valid_o), 128'(3'b000));
      check("t4_idle_data", 128'(out_data_o), 128'(32'h0));
    end
    @(negedge clk);
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h1234_5678;
    #1;
    check("t4_rv", 128'(in_r_valid_o), 128'(3'b100));
    check("t4_rdata", 128'(in_r_data_o), 128'({3{32'h1234_5678}}));

    // 5: response with nothing outstanding
    @(negedge clk); #1;
    check("t5_rv_empty", 128'(in_r_valid_o), 128'(3'b000));
    check("t5_err_pre", 128'(err_o), 128'(1'b0));
    @(negedge clk);
    out_r_valid_i = 1'b0;
    #1;
    check("t5_err_set", 128'(err_o), 128'(1'b1));
    @(negedge clk); #1;
    check("t5_err_sticky", 128'(err_o), 128'(1'b1));
    in_req_i = 3'b111;
    rst      = 1'b1;
    #1;
    check("t5_err_clr", 128'(err_o), 128'(1'b0));
    check("t5_rst_req", 128'(out_req_o), 128'(1'b0));
    check("t5_rst_gnt", 128'(in_gnt_o), 128'(3'b000));

    // 6: reset with 3 outstanding
    @(negedge clk);
    rst      = 1'b0;
    in_req_i = 3'b010;
    #1;
    check("t6_gnt_a", 128'(in_gnt_o), 128'(3'b010));
    @(negedge clk);
    in_req_i = 3'b111;
    #1;
    check("t6_gnt_b", 128'(in_gnt_o), 128'(3'b100));
    @(negedge clk); #1;
    check("t6_gnt_c", 128'(in_gnt_o), 128'(3'b001));
    @(negedge clk);
    in_req_i = '0;
    rst      = 1'b1;
    #1;
    check("t6_rst_rv", 128'(in_r_valid_o), 128'(3'b000));
    @(negedge clk);
    rst           = 1'b0;
    out_r_valid_i = 1'b1;
    #1;
    check("t6_stale_rv", 128'(in_r_valid_o), 128'(3'b000));
    @(negedge clk);
    out_r_valid_i = 1'b0;
    in_req_i      = 3'b111;
    #1;
    check("t6_err", 128'(err_o), 128'(1'b1));
    check("t6_first_gnt", 128'(in_gnt_o), 128'(3'b001));

    @(negedge clk);
    in_req_i = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
